// File: rtl/papuf_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : papuf_eval_ctrl
// Brief    : Sequenced front-end for a bank of pulse-driven arbiter PUF cells.
//            Accepts a challenge, fires VOTES evaluation pulses, samples the
//            synchronised response after each one and returns a per-bit
//            majority-voted response.
//            Optional macro PAPUF_STABILITY_EN adds the rsp_unstable output
//            (per-bit flag: votes were not unanimous).
// Revision : 1.0 - initial release
// ============================================================================
module papuf_eval_ctrl #(
    parameter int CH_W       = 16,
    parameter int RSP_W      = 16,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 4,
    parameter int VOTES      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CH_W-1:0]  req_challenge,
    output logic [CH_W-1:0]  puf_challenge,
    output logic             puf_pulse,
    input  logic [RSP_W-1:0] puf_response,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSP_W-1:0] rsp_data,
    output logic             busy
`ifdef PAPUF_STABILITY_EN
    ,
    output logic [RSP_W-1:0] rsp_unstable
`endif
);

    localparam int c_CW   = $clog2(VOTES + 1);
    localparam int c_IW   = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int c_TMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_PULSE_LAST  = c_TW'(PULSE_CYC - 1);
    localparam logic [c_TW-1:0] c_SETTLE_LAST = c_TW'(SETTLE_CYC - 1);
    localparam logic [c_IW-1:0] c_VOTE_LAST   = c_IW'(VOTES - 1);
    localparam logic [c_CW-1:0] c_HALF        = c_CW'(VOTES / 2);
    localparam logic [c_CW-1:0] c_ALL         = c_CW'(VOTES);

    // An even vote count has no strict majority, so refuse to elaborate.
    generate
        if ((VOTES % 2) == 0 || VOTES < 1) begin : g_votes_must_be_odd
            $error("papuf_eval_ctrl: VOTES must be odd and >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_PULSE  = 3'd2,
        S_SETTLE = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic [c_TW-1:0]   r_timer;
    logic [c_IW-1:0]   r_vote;
    logic [c_CW-1:0]   r_cnt      [RSP_W];
    logic [c_CW-1:0]   w_cnt_next [RSP_W];
    logic [RSP_W-1:0]  w_major;
    logic [RSP_W-1:0]  w_mixed;
    logic [RSP_W-1:0]  r_sync1;
    logic [RSP_W-1:0]  r_sync2;
    logic [CH_W-1:0]   r_challenge;
    logic [RSP_W-1:0]  r_rsp_data;
    logic [RSP_W-1:0]  r_unstable;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_pulse;
    logic              r_rsp_valid;

    // Next-state decode; timed states leave on the last count of r_timer.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = req_valid && r_req_ready;
                if (w_accept) w_next = S_ARM;
            end
            S_ARM:    w_next = S_PULSE;
            S_PULSE:  if (r_timer == c_PULSE_LAST)  w_next = S_SETTLE;
            S_SETTLE: if (r_timer == c_SETTLE_LAST) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_vote == c_VOTE_LAST) ? S_DONE : S_ARM;
            S_DONE:   if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Counter update and vote decision for the sample being taken now.
    always_comb begin
        w_major = '0;
        w_mixed = '0;
        for (int i = 0; i < RSP_W; i++) begin
            w_cnt_next[i] = r_cnt[i] + c_CW'(r_sync2[i]);
            w_major[i]    = (w_cnt_next[i] > c_HALF);
            w_mixed[i]    = (w_cnt_next[i] != '0) && (w_cnt_next[i] != c_ALL);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Cycle timer for PULSE/SETTLE; restarts at every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_timer <= '0;
        else if ((w_next == r_state) && (r_state == S_PULSE || r_state == S_SETTLE))
            r_timer <= r_timer + 1'b1;
        else
            r_timer <= '0;
    end

    // Two-flop synchroniser for the asynchronous PUF outputs, always running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= puf_response;
            r_sync2 <= r_sync1;
        end
    end

    // Challenge capture, vote accumulation and result registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_challenge <= '0;
            r_vote      <= '0;
            r_rsp_data  <= '0;
            r_unstable  <= '0;
            for (int i = 0; i < RSP_W; i++) r_cnt[i] <= '0;
        end else if (w_accept) begin
            r_challenge <= req_challenge;
            r_vote      <= '0;
            for (int i = 0; i < RSP_W; i++) r_cnt[i] <= '0;
        end else if (r_state == S_SAMPLE) begin
            for (int i = 0; i < RSP_W; i++) r_cnt[i] <= w_cnt_next[i];
            if (r_vote == c_VOTE_LAST) begin
                r_rsp_data <= w_major;
                r_unstable <= w_mixed;
            end else begin
                r_vote <= r_vote + 1'b1;
            end
        end
    end

    // Registered status outputs, decoded from the next state so they line up
    // with the state register and are glitch-free at the PUF bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_pulse     <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            r_pulse     <= (w_next == S_PULSE);
            r_rsp_valid <= (w_next == S_DONE);
        end
    end

    assign req_ready     = r_req_ready;
    assign busy          = r_busy;
    assign puf_pulse     = r_pulse;
    assign puf_challenge = r_challenge;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
`ifdef PAPUF_STABILITY_EN
    assign rsp_unstable  = r_unstable;
`else
    logic w_unused_unstable;
    assign w_unused_unstable = ^r_unstable;
`endif

endmodule
`default_nettype wire
